uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, number of data bits per frame; legal range 5..9.
REQ-002 SHALL provide port baud_clk  input  1  bit-rate clock; one serial bit per cycle.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port tx_data  input  DATA_W  word to transmit.
REQ-005 SHALL provide port tx_valid  input  1  tx_data valid.
REQ-006 SHALL provide port tx_ready  output  1  holding buffer can accept a word.
REQ-007 SHALL provide port parity_mode  input  2  00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
REQ-008 SHALL provide port stop2  input  1  0 one stop bit, 1 two stop bits.
REQ-009 SHALL provide port tx_serial  output  1  serial line, idle high.
REQ-010 SHALL provide port busy  output  1  high while a frame is on the line.
REQ-011 SHALL provide port frame_done  output  1  one-cycle pulse on the last stop bit of each frame.

Function
REQ-012 SHALL accept a word on each rising baud_clk edge where tx_valid and tx_ready are both high, writing tx_data, parity_mode and stop2 into a one-entry holding buffer.
REQ-013 SHALL drive tx_ready as the inverse of the buffer-full flag; no write while full, even if the buffer drains that cycle.
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP1, STOP2, each occupying exactly one baud_clk cycle except DATA, which occupies DATA_W cycles.
REQ-015 SHALL move the buffer contents into the shift register and clear buffer-full when in IDLE with buffer full, or in the final stop state with buffer full; the next state SHALL be START.
REQ-016 SHALL therefore drive START (tx_serial=0) in the cycle following the acceptance edge when idle: 1-cycle latency.
REQ-017 SHALL send data bits LSB first in DATA, counting with a ceil(log2(DATA_W))-bit counter that wraps to 0 on leaving DATA.
REQ-018 SHALL go from DATA to PARITY when the latched parity_mode is not 00, otherwise to STOP1.
REQ-019 SHALL compute parity over all DATA_W latched bits: even -> XOR of bits; odd -> inverted XOR; mark -> 1.
REQ-020 SHALL drive tx_serial=1 in STOP1 and STOP2; STOP2 is entered only when latched stop2=1.
REQ-021 SHALL return to IDLE from the final stop state when the buffer is empty; tx_serial=1 in IDLE.
REQ-022 SHALL use frame length 1 + DATA_W + (parity?1:0) + (stop2?2:1) cycles.
REQ-023 SHALL produce back-to-back frames with zero idle cycles when the buffer is full at the final stop state.
REQ-024 SHALL keep config changes on parity_mode/stop2 mid-frame from affecting the frame in flight; values are latched per word at acceptance.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL assert frame_done during the final stop cycle (STOP1 or STOP2).
REQ-027 SHALL register tx_serial directly from a flop so the output is glitch-free.

Reset
REQ-028 SHALL, on rst_n low, immediately force: state IDLE, tx_serial=1, tx_ready=1, busy=0, frame_done=0, buffer-full=0, bit counter=0, shift register all 1s.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame and discard the buffered word; tx_serial SHALL go high asynchronously.
REQ-030 SHALL, after release, accept the first word no earlier than the first rising edge with rst_n high.

Verification
REQ-031 SHALL cover: DATA_W=8, 0xA5, even, stop2=0 -> tx_serial 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; frame_done on cycle 11.
REQ-032 SHALL cover: 0x01, odd -> parity bit 0; same word with even -> parity bit 1; with mark -> 1.
REQ-033 SHALL cover: 0x00, parity none, stop2=1 -> 0, eight 0s, 1, 1 (11 cycles), no PARITY state.
REQ-034 SHALL cover: two words offered continuously, even, 1 stop -> 22 contiguous frame cycles, START of second immediately after first STOP1, tx_ready low while buffer full.
REQ-035 SHALL cover: rst_n pulsed low during DATA bit 3 with a word buffered -> tx_serial=1 at once, tx_ready=1, busy=0, no residual frame after release.
REQ-036 SHALL cover: DATA_W=5 and DATA_W=9 builds, 0x15 / 0x1AA with parity even -> correct bit count and parity.

Source files
------------

// File: rtl/uart_tx_if.sv
// Word handshake between a producer and the UART transmit framer.
interface uart_tx_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: one-entry holding buffer feeding a start/data/parity/stop serializer.
// state  | meaning
// IDLE   | line high, waiting for a buffered word
// START  | start bit (0)
// DATA   | DATA_W data bits, LSB first
// PARITY | parity bit (even/odd/mark)
// STOP1  | first stop bit (1)
// STOP2  | second stop bit (1), only when latched stop2=1
module uart_tx_framer #(
   parameter int DATA_W = 8
) (
   input  logic       baud_clk,
   input  logic       rst_n,
   uart_tx_if.slave   tx_bus,
   input  logic [1:0] parity_mode,
   input  logic       stop2,
   output logic       tx_serial,
   output logic       busy,
   output logic       frame_done
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
   state_t state, state_nxt;

   logic              buf_full;
   logic [DATA_W-1:0] buf_data;
   logic [1:0]        buf_pmode;
   logic              buf_stop2;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic              cur_par_en;
   logic              cur_stop2;
   logic              cur_par_bit;
   logic              accept;
   logic              load;
   logic              last_stop;
   logic              par_bit_nxt;
   logic              tx_serial_nxt;

   assign tx_bus.tx_ready = ~buf_full;
   assign accept          = tx_bus.tx_valid & ~buf_full;
   assign last_stop       = (state == STOP2) || ((state == STOP1) && !cur_stop2);
   assign load            = buf_full && ((state == IDLE) || last_stop);
   assign busy            = (state != IDLE);
   assign frame_done      = last_stop;

   always_comb begin
      case (buf_pmode)
         2'b01:   par_bit_nxt = ^buf_data;
         2'b10:   par_bit_nxt = ~^buf_data;
         default: par_bit_nxt = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      tx_serial_nxt = 1'b1;
      case (state)
         IDLE:    if (buf_full) state_nxt = START;
         START:   state_nxt = DATA;
         DATA:    if (bit_cnt == CNT_LAST) state_nxt = cur_par_en ? PARITY : STOP1;
         PARITY:  state_nxt = STOP1;
         STOP1:   if (cur_stop2) state_nxt = STOP2;
                  else           state_nxt = buf_full ? START : IDLE;
         STOP2:   state_nxt = buf_full ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
      // The line level is chosen from the upcoming state so tx_serial comes straight off a flop.
      case (state_nxt)
         START:   tx_serial_nxt = 1'b0;
         DATA:    tx_serial_nxt = shreg[0];
         PARITY:  tx_serial_nxt = cur_par_bit;
         default: tx_serial_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tx_serial   <= 1'b1;
         buf_full    <= 1'b0;
         buf_data    <= '0;
         buf_pmode   <= '0;
         buf_stop2   <= 1'b0;
         shreg       <= '1;
         bit_cnt     <= '0;
         cur_par_en  <= 1'b0;
         cur_stop2   <= 1'b0;
         cur_par_bit <= 1'b1;
      end else begin
         state     <= state_nxt;
         tx_serial <= tx_serial_nxt;
         if (accept) begin
            buf_full  <= 1'b1;
            buf_data  <= tx_bus.tx_data;
            buf_pmode <= parity_mode;
            buf_stop2 <= stop2;
         end else if (load) begin
            buf_full <= 1'b0;
         end
         if (load) begin
            shreg       <= buf_data;
            cur_par_en  <= |buf_pmode;
            cur_stop2   <= buf_stop2;
            cur_par_bit <= par_bit_nxt;
         end else if (state_nxt == DATA) begin
            shreg <= {1'b1, shreg[DATA_W-1:1]};
         end
         if (state == DATA) begin
            bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: frame scoreboard on the 8-bit build, plus 5- and 9-bit builds.
module tb_uart_tx_framer;
   logic       baud_clk = 1'b0;
   logic       rst_n;
   logic [1:0] parity_mode;
   logic       stop2;
   logic       tx_serial, busy, frame_done;
   logic       tx_serial5, busy5, frame_done5;
   logic       tx_serial9, busy9, frame_done9;

   uart_tx_if #(.DATA_W(8)) bus8 ();
   uart_tx_if #(.DATA_W(5)) bus5 ();
   uart_tx_if #(.DATA_W(9)) bus9 ();

   always #5 baud_clk = ~baud_clk;

   uart_tx_framer #(.DATA_W(8)) u_dut (
      .baud_clk(baud_clk), .rst_n(rst_n), .tx_bus(bus8), .parity_mode(parity_mode),
      .stop2(stop2), .tx_serial(tx_serial), .busy(busy), .frame_done(frame_done));
   uart_tx_framer #(.DATA_W(5)) u_dut5 (
      .baud_clk(baud_clk), .rst_n(rst_n), .tx_bus(bus5), .parity_mode(parity_mode),
      .stop2(stop2), .tx_serial(tx_serial5), .busy(busy5), .frame_done(frame_done5));
   uart_tx_framer #(.DATA_W(9)) u_dut9 (
      .baud_clk(baud_clk), .rst_n(rst_n), .tx_bus(bus9), .parity_mode(parity_mode),
      .stop2(stop2), .tx_serial(tx_serial9), .busy(busy9), .frame_done(frame_done9));

   typedef struct {
      logic [7:0]  data;
      logic [1:0]  pmode;
      logic        stp2;
      int          len;
      logic [15:0] bits;
   } vec_t;

   typedef struct {
      int          len;
      logic [15:0] bits;
   } exp_t;

   vec_t vecs [8];
   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;

   // Frames are compared in time order: first serial bit ends up most significant.
   logic [15:0] acc;
   int          nbits;
   exp_t        e;
   always @(negedge baud_clk) begin
      if (!rst_n) begin
         acc   = '0;
         nbits = 0;
      end else if (busy) begin
         acc = {acc[14:0], tx_serial};
         nbits++;
         if (frame_done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected got len %0d bits %h required no frame", nbits, acc);
            end else begin
               e = exp_q.pop_front();
               if (nbits != e.len || acc != e.bits) begin
                  errors++;
                  $display("FAIL frame got len %0d bits %h required len %0d bits %h",
                           nbits, acc, e.len, e.bits);
               end
            end
            acc   = '0;
            nbits = 0;
         end
      end else begin
         checks++;
         if (tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL idle_line got %b required 1", tx_serial);
         end
      end
   end

   int busy_run = 0;
   int last_run = 0;
   always @(negedge baud_clk) begin
      if (!rst_n) busy_run = 0;
      else if (busy) busy_run++;
      else if (busy_run != 0) begin
         last_run = busy_run;
         busy_run = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((busy || !bus8.tx_ready) && n < max) begin
         @(negedge baud_clk);
         n++;
      end
      chk("idle_timeout", {30'd0, busy, ~bus8.tx_ready}, 32'd0);
   endtask

   task automatic wait_ready(input int max);
      int n = 0;
      while (!bus8.tx_ready && n < max) begin
         @(negedge baud_clk);
         n++;
      end
      chk("ready_timeout", {31'd0, bus8.tx_ready}, 32'd1);
   endtask

   initial begin
      logic [15:0] acc5, acc9;
      int          n5, n9, quiet_bad;
      logic        done5, done9;

      rst_n = 1'b0;
      parity_mode = 2'b00;
      stop2 = 1'b0;
      bus8.tx_valid = 1'b0; bus8.tx_data = '0;
      bus5.tx_valid = 1'b0; bus5.tx_data = '0;
      bus9.tx_valid = 1'b0; bus9.tx_data = '0;

      vecs[0] = '{8'hA5, 2'b01, 1'b0, 11, 16'b0_10100101_0_1};
      vecs[1] = '{8'h01, 2'b10, 1'b0, 11, 16'b0_10000000_0_1};
      vecs[2] = '{8'h01, 2'b01, 1'b0, 11, 16'b0_10000000_1_1};
      vecs[3] = '{8'h01, 2'b11, 1'b0, 11, 16'b0_10000000_1_1};
      vecs[4] = '{8'h00, 2'b00, 1'b1, 11, 16'b0_00000000_1_1};
      vecs[5] = '{8'h3C, 2'b00, 1'b0, 10, 16'b0_00111100_1};
      vecs[6] = '{8'hFF, 2'b10, 1'b1, 12, 16'b0_11111111_1_1_1};
      vecs[7] = '{8'h80, 2'b01, 1'b1, 12, 16'b0_00000001_1_1_1};

      repeat (3) @(negedge baud_clk);
      chk("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
      chk("rst_tx_ready", {31'd0, bus8.tx_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      #2 rst_n = 1'b1;

      // Single frame: latency, and config changes while the frame is in flight.
      @(negedge baud_clk);
      bus8.tx_data = 8'hA5; parity_mode = 2'b01; stop2 = 1'b0; bus8.tx_valid = 1'b1;
      @(posedge baud_clk);
      exp_q.push_back('{len: 11, bits: 16'b0_10100101_0_1});
      #1 bus8.tx_valid = 1'b0; parity_mode = 2'b11; stop2 = 1'b1;
      chk("ready_after_accept", {31'd0, bus8.tx_ready}, 32'd0);
      chk("line_before_start", {31'd0, tx_serial}, 32'd1);
      @(posedge baud_clk);
      #1 chk("start_latency", {31'd0, tx_serial}, 32'd0);
      chk("busy_in_start", {31'd0, busy}, 32'd1);
      wait_idle(40);
      @(negedge baud_clk); #1;
      chk("single_frame_len", last_run, 32'd11);

      // Table: words offered as fast as the buffer takes them.
      @(negedge baud_clk);
      for (int i = 0; i < 8; i++) begin
         bus8.tx_data = vecs[i].data; parity_mode = vecs[i].pmode; stop2 = vecs[i].stp2;
         bus8.tx_valid = 1'b1;
         wait_ready(100);
         @(posedge baud_clk);
         exp_q.push_back('{len: vecs[i].len, bits: vecs[i].bits});
         @(negedge baud_clk);
      end
      bus8.tx_valid = 1'b0;
      wait_idle(200);
      @(negedge baud_clk); #1;
      chk("table_contiguous_len", last_run, 32'd89);

      // Two words back to back, even parity, one stop bit.
      @(negedge baud_clk);
      bus8.tx_data = 8'hA5; parity_mode = 2'b01; stop2 = 1'b0; bus8.tx_valid = 1'b1;
      @(posedge baud_clk);
      exp_q.push_back('{len: 11, bits: 16'b0_10100101_0_1});
      @(negedge baud_clk);
      bus8.tx_data = 8'h3C;
      wait_ready(10);
      @(posedge baud_clk);
      exp_q.push_back('{len: 11, bits: 16'b0_00111100_0_1});
      #1 bus8.tx_valid = 1'b0;
      chk("b2b_ready_low_full", {31'd0, bus8.tx_ready}, 32'd0);
      wait_idle(60);
      @(negedge baud_clk); #1;
      chk("b2b_contiguous_len", last_run, 32'd22);

      // Reset during data bit 3 with a second word buffered.
      @(negedge baud_clk);
      bus8.tx_data = 8'hA5; parity_mode = 2'b01; stop2 = 1'b0; bus8.tx_valid = 1'b1;
      @(posedge baud_clk);
      @(negedge baud_clk);
      bus8.tx_data = 8'hFF;
      wait_ready(10);
      @(posedge baud_clk);
      #1 bus8.tx_valid = 1'b0;
      repeat (3) @(posedge baud_clk);
      @(negedge baud_clk);
      chk("data_bit3_level", {31'd0, tx_serial}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_tx_serial", {31'd0, tx_serial}, 32'd1);
      chk("abort_tx_ready", {31'd0, bus8.tx_ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_frame_done", {31'd0, frame_done}, 32'd0);
      @(negedge baud_clk);
      #2 rst_n = 1'b1;
      quiet_bad = 0;
      repeat (30) begin
         @(negedge baud_clk);
         if (busy || !tx_serial || !bus8.tx_ready) quiet_bad++;
      end
      chk("no_residual_frame", quiet_bad, 32'd0);

      // 5-bit and 9-bit builds, even parity, one stop bit.
      @(negedge baud_clk);
      bus5.tx_data = 5'h15; bus9.tx_data = 9'h1AA;
      parity_mode = 2'b01; stop2 = 1'b0;
      bus5.tx_valid = 1'b1; bus9.tx_valid = 1'b1;
      @(posedge baud_clk);
      #1 bus5.tx_valid = 1'b0; bus9.tx_valid = 1'b0;
      acc5 = '0; acc9 = '0; n5 = 0; n9 = 0; done5 = 1'b0; done9 = 1'b0;
      for (int c = 0; c < 30 && !(done5 && done9); c++) begin
         @(negedge baud_clk);
         if (busy5 && !done5) begin
            acc5 = {acc5[14:0], tx_serial5}; n5++;
            if (frame_done5) done5 = 1'b1;
         end
         if (busy9 && !done9) begin
            acc9 = {acc9[14:0], tx_serial9}; n9++;
            if (frame_done9) done9 = 1'b1;
         end
      end
      chk("w5_len", n5, 32'd8);
      chk("w5_bits", {16'd0, acc5}, {16'd0, 16'b0_10101_1_1});
      chk("w9_len", n9, 32'd12);
      chk("w9_bits", {16'd0, acc9}, {16'd0, 16'b0_010101011_1_1});

      repeat (5) @(negedge baud_clk);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
